// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MIPS HI/LO multiply/divide unit with pipeline stall request.
// Results are computed at the start edge and held pending until the busy window ends.
module mdu_ctrl #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MdUseD,
    output logic        Busy,
    output logic        StallReq,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int CW = $clog2((MUL_CYC > DIV_CYC ? MUL_CYC : DIV_CYC) + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state = IDLE;
    state_t        state_nx;
    logic [CW-1:0] cnt = '0;
    logic [31:0]   p_hi = '0, p_lo = '0, hi_q = '0, lo_q = '0;
    logic          start_md, div_op, neg_a, neg_b;
    logic [31:0]   mag_a, mag_b, dvs, quo, rem, res_hi, res_lo;
    logic [63:0]   prod;
    assign HI = hi_q;
    assign LO = lo_q;
    // Sign-magnitude division makes 0x80000000 / -1 fall out naturally as 0x80000000 rem 0.
    always_comb begin
        start_md = Start && !Op[2];
        div_op   = Op[1];
        neg_a    = !Op[0] && A[31];
        neg_b    = !Op[0] && B[31];
        mag_a    = neg_a ? -A : A;
        mag_b    = neg_b ? -B : B;
        dvs      = (mag_b == '0) ? 32'd1 : mag_b;
        quo      = mag_a / dvs;
        rem      = mag_a % dvs;
        prod     = {{32{neg_a}}, A} * {{32{neg_b}}, B};
        res_hi   = !div_op ? prod[63:32] : (B == '0) ? hi_q : neg_a ? -rem : rem;
        res_lo   = !div_op ? prod[31:0] : (B == '0) ? lo_q : (neg_a ^ neg_b) ? -quo : quo;
    end
    always_ff @(posedge Clk) begin
        state <= Reset ? IDLE : state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE) ? (start_md ? RUN : IDLE) : (cnt == CW'(1) ? IDLE : RUN);
    end
    always_comb begin
        Busy     = (state == RUN);
        StallReq = MdUseD && ((state == RUN) || start_md);
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt  <= '0;
            p_hi <= '0;
            p_lo <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == IDLE) begin
            if (start_md) begin
                cnt  <= div_op ? CW'(DIV_CYC) : CW'(MUL_CYC);
                p_hi <= res_hi;
                p_lo <= res_lo;
            end else if (Start && Op == 3'd4) begin
                hi_q <= A;
            end else if (Start && Op == 3'd5) begin
                lo_q <= A;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                hi_q <= p_hi;
                lo_q <= p_lo;
            end
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl; commits are checked by a monitor on Busy falling.
module tb_mdu_ctrl;
    logic        Clk = 0, Reset = 1, Start = 0, MdUseD = 0;
    logic [2:0]  Op = '0;
    logic [31:0] A = '0, B = '0;
    logic        Busy, StallReq;
    logic [31:0] HI, LO;
    int checks = 0, errors = 0;
    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;
    exp_t q[$];
    logic prev_busy = 0;
    int   run_len = 0;

    mdu_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .MdUseD(MdUseD), .Busy(Busy), .StallReq(StallReq), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (Start && Busy) begin
            errors++;
            $display("FAIL start_in_run: Start=1 while Busy=1");
        end
        if (Busy) begin
            run_len++;
        end else if (prev_busy) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got HI=%h LO=%h expected no commit", HI, LO);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_len"}, run_len, e.len);
                chk({e.name, "_hi"}, HI, e.hi);
                chk({e.name, "_lo"}, LO, e.lo);
            end
            run_len = 0;
        end
        prev_busy = Busy;
    end

    task automatic issue(input string n, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input int len);
        q.push_back('{n, ehi, elo, len});
        Start = 1; Op = op; A = a; B = b;
        #1 chk({n, "_stall_start"}, 32'(StallReq), 32'(MdUseD));
        tick();
        Start = 0; A = ~a; B = b + 32'd1;
        for (int i = 0; i < 40 && Busy; i++) begin
            chk({n, "_stall_busy"}, 32'(StallReq), 32'(MdUseD));
            tick();
        end
        chk({n, "_done"}, 32'(Busy), 32'd0);
        chk({n, "_stall_idle"}, 32'(StallReq), 32'd0);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        Start = 1; Op = op; A = a;
        tick();
        Start = 0;
        chk("mt_busy", 32'(Busy), 32'd0);
    endtask

    initial begin
        tick(); tick();
        Reset = 0;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        MdUseD = 1; Start = 1; Op = 3'd2;
        #1 chk("stall_comb_start", 32'(StallReq), 32'd1);
        Start = 0;
        #1 chk("stall_comb_idle", 32'(StallReq), 32'd0);
        MdUseD = 0;
        tick();
        issue("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        issue("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5);
        issue("div", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue("divu", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        mt(3'd4, 32'h1234);
        chk("mthi_hi", HI, 32'h1234);
        chk("mthi_lo", LO, 32'd3);
        mt(3'd5, 32'h5678);
        chk("mtlo_lo", LO, 32'h5678);
        chk("mtlo_hi", HI, 32'h1234);
        issue("divu_zero", 3'd3, 32'd99, 32'd0, 32'h1234, 32'h5678, 10);
        issue("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
        issue("div_negb", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10);
        MdUseD = 1;
        issue("mult_stall", 3'd0, 32'd5, 32'd7, 32'd0, 32'h23, 5);
        MdUseD = 0;
        Start = 1; Op = 3'd6; A = 32'hDEADBEEF;
        tick();
        Op = 3'd7;
        tick();
        Start = 0;
        chk("rsvd_busy", 32'(Busy), 32'd0);
        chk("rsvd_hi", HI, 32'd0);
        chk("rsvd_lo", LO, 32'h23);
        Op = 3'd4; A = 32'hFFFFFFFF;
        repeat (3) tick();
        chk("idle_hold_hi", HI, 32'd0);
        chk("idle_hold_lo", LO, 32'h23);
        mt(3'd5, 32'hA);
        chk("b2b_mtlo", LO, 32'hA);
        issue("b2b_mult", 3'd0, 32'd2, 32'd3, 32'd0, 32'd6, 5);
        q.push_back('{"div_reset_abort", 32'd0, 32'd0, 3});
        Start = 1; Op = 3'd2; A = 32'd100; B = 32'd3;
        tick();
        Start = 0;
        tick(); tick();
        Reset = 1;
        tick();
        Reset = 0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        repeat (15) tick();
        chk("abort_late_busy", 32'(Busy), 32'd0);
        chk("abort_late_hi", HI, 32'd0);
        chk("abort_late_lo", LO, 32'd0);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL use the parameter MUL_CYC, default 5, meaning the busy cycles for MULT/MULTU.
REQ-002 The block SHALL use the parameter DIV_CYC, default 10, meaning the busy cycles for DIV/DIVU.
REQ-003 The block SHALL provide the following ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  an MD instruction is in EX this cycle.
- Op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved.
- A  in  32  rs operand (forwarded).
- B  in  32  rt operand (forwarded).
- MdUseD  in  1  the instruction in ID reads or writes HI/LO (mult*/div*/mfhi/mflo/mthi/mtlo).
- Busy  out  1  an operation is in progress.
- StallReq  out  1  freezes PC and IF/ID and bubbles ID/EX.
- HI  out  32  HI register.
- LO  out  32  LO register.

Function
REQ-004 The block SHALL be a two-state FSM, IDLE and RUN, with a cycle counter Cnt and pending result registers PHi/PLo.
REQ-005 In IDLE with Start=1 and Op in 0-3, the block SHALL, at the edge, compute the result into PHi/PLo, load Cnt with MUL_CYC or DIV_CYC, and enter RUN.
REQ-006 In RUN, the block SHALL decrement Cnt on each edge; on the edge where Cnt=1, it SHALL copy PHi to HI and PLo to LO, and return to IDLE.
REQ-007 Busy SHALL equal (state==RUN); an op started at edge t0 SHALL hold Busy=1 for exactly N cycles, with HI/LO visible in the first IDLE cycle.
REQ-008 MULT SHALL produce the signed 64-bit product {HI,LO}; MULTU SHALL produce the unsigned product.
REQ-009 DIV SHALL produce a signed quotient in LO truncated toward zero, and a remainder in HI carrying the sign of the dividend; DIVU SHALL perform the same operation unsigned.
REQ-010 For division by zero (B==0), the block SHALL still run DIV_CYC cycles but leave HI and LO unchanged.
REQ-011 For DIV with A=0x80000000 and B=0xFFFFFFFF, the block SHALL set LO=0x80000000 and HI=0.
REQ-012 For MTHI or MTLO with Start=1 in IDLE, the block SHALL write A to HI or LO respectively at that edge, with no RUN state and Busy staying 0.
REQ-013 StallReq SHALL be combinational: MdUseD && (Busy || (Start && Op<=3)).
REQ-014 Start while in RUN SHALL be ignored, with state, Cnt, and pending results unchanged; the hazard unit guarantees this never occurs, and the bench flags it.
REQ-015 Reserved Op with Start=1 SHALL be a no-op.
REQ-016 Start=0 in IDLE SHALL hold all state.
REQ-017 Operands SHALL be sampled only at the start edge; changes to A/B during RUN SHALL have no effect on the result.

Reset
REQ-018 On Reset=1 at a posedge, the block SHALL set state=IDLE, Cnt=0, PHi=PLo=0, HI=LO=0, and Busy=0; StallReq then depends only on the inputs.
REQ-019 Reset during RUN SHALL abort the operation, with no commit of pending results.
REQ-020 Reset SHALL take priority over Start in the same cycle.
REQ-021 Outputs before the first reset are don't-care, but the implementation SHALL initialise every register to 0 for simulation.

Verification
REQ-022 MULT with A=0xFFFFFFFE (-2) and B=3 -> Busy high for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002 and LO=0xFFFFFFFA.
REQ-023 DIV with A=-7 and B=2 -> Busy high for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF; DIVU with A=7 and B=2 -> LO=3 and HI=1.
REQ-024 DIVU with B=0 after MTHI 0x1234 and MTLO 0x5678 -> Busy high for 10 cycles, then HI=0x1234 and LO=0x5678 unchanged.
REQ-025 Start MULT, then hold MdUseD=1 (mflo in ID) -> StallReq=1 from the start cycle through the last Busy cycle, then 0 in the cycle LO is valid.
REQ-026 Assert Reset at cycle 3 of a DIV -> the next cycle shows Busy=0 and HI=LO=0, and no later commit occurs.
REQ-027 Run a back-to-back MTLO 0xA then MULT 2*3 -> LO=0xA the cycle after MTLO, then LO=6 and HI=0 after 5 Busy cycles.
